// File: rtl/traffic_ctrl_param.sv
// Parametrised two-road traffic-light controller with built-in 1 Hz divider,
// pedestrian walk phase, night flashing-yellow mode and BCD countdowns.
module traffic_ctrl_param #(
    parameter int unsigned CLK_DIV  = 50_000_000,
    parameter int unsigned T_GREEN  = 25,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_WALK   = 10
) (
    input  logic       s_clk,
    input  logic       rst,
    input  logic       night_mode,
    input  logic       ped_req,
    output logic [2:0] light_1,
    output logic [2:0] light_2,
    output logic [7:0] bcd_1,
    output logic [7:0] bcd_2,
    output logic       ped_walk,
    output logic       tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [6:0]  C_G   = 7'(T_GREEN);
    localparam logic [6:0]  C_Y   = 7'(T_YELLOW);
    localparam logic [6:0]  C_AR  = 7'(T_ALLRED);
    localparam logic [6:0]  C_W   = 7'(T_WALK);
    localparam logic [2:0]  L_RED = 3'b100;
    localparam logic [2:0]  L_YEL = 3'b010;
    localparam logic [2:0]  L_GRN = 3'b001;

    typedef enum logic [2:0] {
        S_AR2, S_G1, S_Y1, S_AR1, S_G2, S_Y2, S_WALK, S_NIGHT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [6:0]         r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0]   r_div;
    logic               r_ped_pend, w_ped_pend_nxt;
    logic               r_next_road2, w_next_road2_nxt;
    logic               r_blink, w_blink_nxt;
    logic               w_tick, w_walk_entry;
    logic [6:0]         w_d1, w_d2, w_p;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));
    assign tick   = w_tick;

    always_ff @(posedge s_clk or posedge rst) begin
        if (rst) begin
            r_div        <= '0;
            r_state      <= S_AR2;
            r_cnt        <= C_AR;
            r_ped_pend   <= 1'b0;
            r_next_road2 <= 1'b0;
            r_blink      <= 1'b1;
        end else begin
            r_div        <= w_tick ? '0 : r_div + DIV_W'(1);
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ped_pend   <= w_ped_pend_nxt;
            r_next_road2 <= w_next_road2_nxt;
            r_blink      <= w_blink_nxt;
        end
    end

    // Phase sequencing; everything advances only on tick cycles.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_blink_nxt      = r_blink;
        w_next_road2_nxt = r_next_road2;
        w_walk_entry     = 1'b0;
        if (w_tick) begin
            if (r_state == S_NIGHT) begin
                w_blink_nxt = ~r_blink;
                if (!night_mode) begin
                    w_state_nxt = S_AR2;
                    w_cnt_nxt   = C_AR;
                end
            end else if (r_cnt == 7'd1) begin
                case (r_state)
                    S_G1: begin w_state_nxt = S_Y1;  w_cnt_nxt = C_Y;  end
                    S_Y1: begin w_state_nxt = S_AR1; w_cnt_nxt = C_AR; end
                    S_G2: begin w_state_nxt = S_Y2;  w_cnt_nxt = C_Y;  end
                    S_Y2: begin w_state_nxt = S_AR2; w_cnt_nxt = C_AR; end
                    S_AR1, S_AR2: begin
                        if (night_mode) begin
                            w_state_nxt = S_NIGHT;
                            w_blink_nxt = 1'b1;
                        end else if (r_ped_pend) begin
                            w_state_nxt      = S_WALK;
                            w_cnt_nxt        = C_W;
                            w_next_road2_nxt = (r_state == S_AR1);
                            w_walk_entry     = 1'b1;
                        end else begin
                            w_state_nxt = (r_state == S_AR1) ? S_G2 : S_G1;
                            w_cnt_nxt   = C_G;
                        end
                    end
                    S_WALK: begin
                        w_state_nxt = r_next_road2 ? S_G2 : S_G1;
                        w_cnt_nxt   = C_G;
                    end
                    default: ;
                endcase
            end else begin
                w_cnt_nxt = r_cnt - 7'd1;
            end
        end
        // A press coinciding with walk entry stays pending.
        w_ped_pend_nxt = ped_req | (r_ped_pend & ~w_walk_entry);
    end

    // Lamps and countdowns decoded from registered state.
    always_comb begin
        light_1  = L_RED;
        light_2  = L_RED;
        ped_walk = 1'b0;
        w_p      = r_ped_pend ? C_W : 7'd0;
        w_d1     = r_cnt;
        w_d2     = r_cnt;
        case (r_state)
            S_G1:  begin light_1 = L_GRN; w_d2 = r_cnt + C_Y + C_AR + w_p; end
            S_Y1:  begin light_1 = L_YEL; w_d2 = r_cnt + C_AR + w_p; end
            S_AR1: begin
                w_d2 = r_cnt + w_p;
                w_d1 = r_cnt + w_p + C_G + C_Y + C_AR;
            end
            S_G2:  begin light_2 = L_GRN; w_d1 = r_cnt + C_Y + C_AR + w_p; end
            S_Y2:  begin light_2 = L_YEL; w_d1 = r_cnt + C_AR + w_p; end
            S_AR2: begin
                w_d1 = r_cnt + w_p;
                w_d2 = r_cnt + w_p + C_G + C_Y + C_AR;
            end
            S_WALK: begin
                ped_walk = 1'b1;
                if (r_next_road2) w_d1 = r_cnt + C_G + C_Y + C_AR;
                else              w_d2 = r_cnt + C_G + C_Y + C_AR;
            end
            S_NIGHT: begin
                light_1 = {1'b0, r_blink, 1'b0};
                light_2 = {1'b0, r_blink, 1'b0};
            end
            default: ;
        endcase
        bcd_1 = (r_state == S_NIGHT) ? 8'hFF : to_bcd(w_d1);
        bcd_2 = (r_state == S_NIGHT) ? 8'hFF : to_bcd(w_d2);
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed self-checking bench for traffic_ctrl_param with short timings
// (CLK_DIV=4, green 5, yellow 2, all-red 1, walk 3).
module tb_traffic_ctrl_param;

    logic       s_clk = 1'b0;
    logic       rst, night_mode, ped_req;
    logic [2:0] light_1, light_2;
    logic [7:0] bcd_1, bcd_2;
    logic       ped_walk, tick;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t_g1, n;

    traffic_ctrl_param #(
        .CLK_DIV(4), .T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(3)
    ) dut (
        .s_clk(s_clk), .rst(rst), .night_mode(night_mode), .ped_req(ped_req),
        .light_1(light_1), .light_2(light_2), .bcd_1(bcd_1), .bcd_2(bcd_2),
        .ped_walk(ped_walk), .tick(tick)
    );

    always #5 s_clk = ~s_clk;
    always @(posedge s_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] l1, input logic [2:0] l2,
                              input logic [7:0] b1, input logic [7:0] b2, input logic pw);
        chk({tag, "_light1"}, 32'(light_1), 32'(l1));
        chk({tag, "_light2"}, 32'(light_2), 32'(l2));
        chk({tag, "_bcd1"},   32'(bcd_1),   32'(b1));
        chk({tag, "_bcd2"},   32'(bcd_2),   32'(b2));
        chk({tag, "_walk"},   32'(ped_walk), 32'(pw));
    endtask

    // Called at a falling edge; returns at the falling edge after the next tick is consumed.
    task automatic step_tick();
        int k = 0;
        while (tick !== 1'b1 && k < 16) begin
            @(negedge s_clk);
            k++;
        end
        chk("tick_wait", 32'(tick), 32'd1);
        @(negedge s_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; night_mode = 1'b0; ped_req = 1'b0;
        repeat (3) @(negedge s_clk);
        expect_out("rst_hold", 3'b100, 3'b100, 8'h01, 8'h09, 1'b0);
        chk("rst_tick", 32'(tick), 32'd0);

        // Reset release and first tick
        rst = 1'b0;
        n = 0;
        while (light_1 !== 3'b001 && n < 20) begin
            @(negedge s_clk);
            n++;
            if (n < 3)       chk("tick_early", 32'(tick), 32'd0);
            else if (n == 3) chk("tick_first", 32'(tick), 32'd1);
        end
        chk("first_tick_cycles", 32'(n), 32'd4);
        t_g1 = cyc;

        // Free run
        expect_out("g1_entry", 3'b001, 3'b100, 8'h05, 8'h08, 1'b0);
        repeat (4) step_tick();
        expect_out("g1_last", 3'b001, 3'b100, 8'h01, 8'h04, 1'b0);
        step_tick();
        expect_out("y1", 3'b010, 3'b100, 8'h02, 8'h03, 1'b0);
        repeat (2) step_tick();
        expect_out("ar1", 3'b100, 3'b100, 8'h09, 8'h01, 1'b0);
        step_tick();
        expect_out("g2", 3'b100, 3'b001, 8'h08, 8'h05, 1'b0);
        repeat (7) step_tick();
        expect_out("ar2", 3'b100, 3'b100, 8'h01, 8'h09, 1'b0);
        step_tick();
        chk("period", 32'(cyc - t_g1), 32'd64);
        expect_out("g1_again", 3'b001, 3'b100, 8'h05, 8'h08, 1'b0);

        // Pedestrian press during G1
        ped_req = 1'b1;
        @(negedge s_clk);
        ped_req = 1'b0;
        step_tick();
        expect_out("ped_g1", 3'b001, 3'b100, 8'h04, 8'h10, 1'b0);
        repeat (4) step_tick();
        expect_out("ped_y1", 3'b010, 3'b100, 8'h02, 8'h06, 1'b0);
        repeat (2) step_tick();
        expect_out("ped_ar1", 3'b100, 3'b100, 8'h12, 8'h04, 1'b0);
        step_tick();
        expect_out("walk", 3'b100, 3'b100, 8'h11, 8'h03, 1'b1);
        repeat (2) step_tick();
        expect_out("walk_end", 3'b100, 3'b100, 8'h09, 8'h01, 1'b1);
        step_tick();
        expect_out("walk_g2", 3'b100, 3'b001, 8'h08, 8'h05, 1'b0);
        repeat (8) step_tick();
        expect_out("after_walk_g1", 3'b001, 3'b100, 8'h05, 8'h08, 1'b0);

        // Night mode requested during G2
        repeat (8) step_tick();
        chk("night_g2", 32'(light_2), 32'(3'b001));
        night_mode = 1'b1;
        repeat (5) step_tick();
        expect_out("night_y2", 3'b100, 3'b010, 8'h03, 8'h02, 1'b0);
        repeat (2) step_tick();
        expect_out("night_ar2", 3'b100, 3'b100, 8'h01, 8'h09, 1'b0);
        step_tick();
        expect_out("night_on", 3'b010, 3'b010, 8'hFF, 8'hFF, 1'b0);
        step_tick();
        expect_out("night_off", 3'b000, 3'b000, 8'hFF, 8'hFF, 1'b0);
        step_tick();
        expect_out("night_on_b", 3'b010, 3'b010, 8'hFF, 8'hFF, 1'b0);
        night_mode = 1'b0;
        step_tick();
        expect_out("night_exit_ar2", 3'b100, 3'b100, 8'h01, 8'h09, 1'b0);
        step_tick();
        expect_out("night_exit_g1", 3'b001, 3'b100, 8'h05, 8'h08, 1'b0);

        // Pedestrian press while in night mode
        night_mode = 1'b1;
        repeat (8) step_tick();
        expect_out("night2_on", 3'b010, 3'b010, 8'hFF, 8'hFF, 1'b0);
        ped_req = 1'b1;
        @(negedge s_clk);
        ped_req = 1'b0;
        night_mode = 1'b0;
        step_tick();
        expect_out("night2_ar2", 3'b100, 3'b100, 8'h04, 8'h12, 1'b0);
        step_tick();
        expect_out("night2_walk", 3'b100, 3'b100, 8'h03, 8'h11, 1'b1);
        repeat (3) step_tick();
        expect_out("night2_g1", 3'b001, 3'b100, 8'h05, 8'h08, 1'b0);

        // Asynchronous reset during Y2
        repeat (13) step_tick();
        expect_out("pre_rst_y2", 3'b100, 3'b010, 8'h03, 8'h02, 1'b0);
        #2 rst = 1'b1;
        #1;
        expect_out("rst_async", 3'b100, 3'b100, 8'h01, 8'h09, 1'b0);
        chk("rst_async_tick", 32'(tick), 32'd0);
        @(negedge s_clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
